// File: rtl/aes_pkg.sv
// Shared AES constants, round-key types and the key-schedule sequencer state encoding.
package aes_pkg;

    localparam int AES_NB    = 4;
    localparam int AES128_NK = 4;
    localparam int AES128_NR = 10;

    typedef logic [0:127] round_key_t;
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        FILL,
        REV
    } ks_state_t;

    // Round constant for rounds 1..10; any other round yields zero.
    function automatic logic [7:0] aes_rcon(input round_idx_t round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keyExpansion.sv
// Combinational single-round key expansion: derives round key 'round' from the previous round key.
module keyExpansion
    import aes_pkg::*;
#(
    parameter int nk = 4
) (
    input  round_key_t key,
    input  round_idx_t round,
    output round_key_t key_out
);

    if (nk != AES128_NK) begin : g_bad_nk
        $error("keyExpansion: only nk=4 is supported");
    end

    logic [31:0] w_w [AES_NB];
    logic [31:0] w_n [AES_NB];
    logic [31:0] w_temp;

    // RotWord + Rcon only; this stage carries no SubWord.
    always_comb begin
        for (int unsigned i = 0; i < AES_NB; i++) begin
            w_w[i] = key[32*i +: 32];
        end
        w_temp = {w_w[AES_NB-1][23:0], w_w[AES_NB-1][31:24]} ^ {aes_rcon(round), 24'h000000};
        w_n[0] = w_w[0] ^ w_temp;
        for (int unsigned i = 1; i < AES_NB; i++) begin
            w_n[i] = w_n[i-1] ^ w_w[i];
        end
        key_out = '0;
        for (int unsigned i = 0; i < AES_NB; i++) begin
            key_out[32*i +: 32] = w_n[i];
        end
    end

endmodule

// File: rtl/key_schedule_sequencer.sv
// Steps keyExpansion once per cycle, stores all round keys, and streams them
// forward or reverse over a valid/ready interface, with replay from the store.
module key_schedule_sequencer
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [0:127] key_in,
    input  logic         dec,
    input  logic         replay,
    input  logic         abort,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         store_valid
);

    if (NK != AES128_NK || NR != AES128_NR) begin : g_bad_nk
        $error("key_schedule_sequencer: only NK=4 (AES-128) is supported");
    end

    localparam round_idx_t LAST = round_idx_t'(NR);

    ks_state_t  r_state, w_state_nxt;
    round_key_t r_cur, w_cur_nxt;
    round_idx_t r_idx, w_idx_nxt;
    logic       r_store_valid, w_sv_nxt;
    logic       r_up, w_up_nxt;
    logic       r_replay, w_replay_nxt;

    round_key_t r_store [NR+1];
    logic       w_we;
    round_idx_t w_waddr;
    round_key_t w_wdata;

    round_key_t w_exp;
    round_idx_t w_round;
    round_idx_t w_end;
    logic       w_hs;

    assign w_round = r_idx + 4'd1;

    keyExpansion #(.nk(NK)) u_key_expansion (
        .key     (r_cur),
        .round   (w_round),
        .key_out (w_exp)
    );

    // Stream end: forward runs (FWD, forward replay) finish at NR, reverse runs at 0.
    assign w_end       = (r_state == FWD || r_up) ? LAST : 4'd0;
    assign key_ready   = (r_state == IDLE);
    assign rk_valid    = (r_state == FWD) || (r_state == REV);
    assign w_hs        = rk_valid && rk_ready;
    assign rk_index    = r_idx;
    assign rk_last     = rk_valid && (r_idx == w_end);
    assign store_valid = r_store_valid;

    always_comb begin
        rk_data = '0;
        if (r_state == FWD) begin
            rk_data = r_cur;
        end else if (r_state == REV) begin
            rk_data = r_store[r_idx];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_idx_nxt    = r_idx;
        w_sv_nxt     = r_store_valid;
        w_up_nxt     = r_up;
        w_replay_nxt = r_replay;
        w_we         = 1'b0;
        w_waddr      = w_round;
        w_wdata      = w_exp;

        case (r_state)
            IDLE: begin
                if (key_load) begin
                    w_cur_nxt    = key_in;
                    w_we         = 1'b1;
                    w_waddr      = 4'd0;
                    w_wdata      = key_in;
                    w_idx_nxt    = 4'd0;
                    w_sv_nxt     = 1'b0;
                    w_up_nxt     = 1'b0;
                    w_replay_nxt = 1'b0;
                    w_state_nxt  = dec ? FILL : FWD;
                end else if (replay && r_store_valid) begin
                    w_up_nxt     = !dec;
                    w_idx_nxt    = dec ? LAST : 4'd0;
                    w_replay_nxt = 1'b1;
                    w_state_nxt  = REV;
                end
            end
            FWD: begin
                if (w_hs) begin
                    if (r_idx == LAST) begin
                        w_sv_nxt    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cur_nxt = w_exp;
                        w_we      = 1'b1;
                        w_idx_nxt = w_round;
                    end
                end
            end
            FILL: begin
                w_cur_nxt = w_exp;
                w_we      = 1'b1;
                w_idx_nxt = w_round;
                if (w_round == LAST) begin
                    w_sv_nxt    = 1'b1;
                    w_up_nxt    = 1'b0;
                    w_state_nxt = REV;
                end
            end
            REV: begin
                if (w_hs) begin
                    if (r_idx == w_end) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_up ? (r_idx + 4'd1) : (r_idx - 4'd1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Abort overrides the whole case above; a replay keeps its already-complete store.
        if (abort) begin
            w_state_nxt  = IDLE;
            w_cur_nxt    = r_cur;
            w_idx_nxt    = r_idx;
            w_up_nxt     = r_up;
            w_replay_nxt = r_replay;
            w_we         = 1'b0;
            w_sv_nxt     = r_store_valid;
            if (r_state != IDLE && !r_replay) begin
                w_sv_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cur         <= '0;
            r_idx         <= '0;
            r_store_valid <= 1'b0;
            r_up          <= 1'b0;
            r_replay      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur         <= w_cur_nxt;
            r_idx         <= w_idx_nxt;
            r_store_valid <= w_sv_nxt;
            r_up          <= w_up_nxt;
            r_replay      <= w_replay_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_store[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: doc/key_schedule_sequencer.md
Name: key_schedule_sequencer

Overview:
Sequential round-key generator that sits upstream of the existing combinational keyExpansion stage and drives it. It registers the cipher key and steps keyExpansion once per cycle with the correct round index, storing all 11 round keys. It streams round keys to the cipher/decipher round datapath over a valid/ready interface, in forward order for encryption and reverse order for decryption. It can replay the stored schedule without re-expanding.

Parameters:
NK, 4, key length in 32-bit words; only 4 (AES-128) is legal, any other value is an elaboration error.
NR, NK+6, number of rounds; round keys are indexed 0..NR.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
key_load  input  1  load request; accepted when key_load & key_ready.
key_in  input  128  cipher key, bit vector [0:127], word 0 = bits [0:31].
dec  input  1  order select, sampled at load/replay acceptance: 0 = forward 0..10, 1 = reverse 10..0.
replay  input  1  re-stream the stored schedule; accepted in IDLE when store_valid=1 and key_load=0.
abort  input  1  synchronous cancel.
key_ready  output  1  high only in IDLE.
rk_valid  output  1  round key available.
rk_ready  input  1  downstream accepts round key.
rk_data  output  128  round key, [0:127].
rk_index  output  4  round index of rk_data.
rk_last  output  1  high with the final key of the stream (index 10 forward, index 0 reverse).
store_valid  output  1  all 11 keys in the store belong to the last loaded key.

Behaviour:
- Reset state: IDLE. Outputs: rk_valid=0, rk_data=0, rk_index=0, rk_last=0, store_valid=0, key_ready=1. Store contents are don't-care.
- States: IDLE, FWD, FILL, REV.
- Sub-module keyExpansion (nk=4) is driven with key=current key register and round=rk_index+1. It is pure combinational: RotWord + Rcon, no SubWord in the current stage. The expected values below follow that transform.
- Load accepted at cycle T:
  - cur<=key_in, store[0]<=key_in, rk_index<=0, store_valid<=0.
  - dec=0 goes to FWD; dec=1 goes to FILL.
- FWD:
  - rk_valid=1 from T+1, rk_data=cur.
  - On handshake with index<10: cur<=expansion output, store[index+1]<=same, index++.
  - On handshake at index 10: store_valid<=1, return to IDLE.
  - Maximum throughput is one key per cycle.
- FILL:
  - rk_valid=0. Each cycle cur<=expansion output, store[index+1]<=same, index++.
  - When index reaches 10: store_valid<=1, rk_index<=10, go to REV. First rk_valid is at T+11.
- REV:
  - rk_valid=1, rk_data=store[rk_index]. Decrement on handshake.
  - Handshake at index 0 returns to IDLE.
- Replay accepted in IDLE: no expansion is performed.
  - dec=0: rk_index<=0, stream store[0..10] in REV-style read (same as REV, incrementing).
  - dec=1: rk_index<=10, go to REV.
  - First rk_valid is the next cycle. store_valid stays 1.
- Backpressure: while rk_valid & !rk_ready, rk_data, rk_index and rk_last hold stable and no expansion occurs.
- Simultaneous events:
  - key_load and replay in IDLE: key_load wins.
  - key_load outside IDLE is ignored (key_ready=0).
  - abort has priority over everything except reset. Next cycle: IDLE, rk_valid=0. store_valid<=0 unless the store was already complete before this stream (i.e. abort during replay keeps 1).
- rk_valid deasserts the cycle after the last handshake; a new load is accepted in that IDLE cycle at the earliest.
- Reset mid-stream: immediate IDLE and all outputs return to reset values, asynchronously.

Decomposition:
- Shared package aes_pkg:
  - AES_NB=4, AES128_NK=4, AES128_NR=10.
  - round-key typedef (128-bit, [0:127]).
  - round-index typedef (4-bit).
  - ks_state_t enum {IDLE, FWD, FILL, REV}.
- One sub-module instance: the existing keyExpansion (nk=4).
- Round-key store (11x128 register array, one write port, one read port) is kept inline; no separate module.

Test Plan:
- Zero key, dec=0, rk_ready=1: 11 consecutive rk_valid cycles starting T+1.
  - index 0 = 0, index 1 = 01000000 01000000 01000000 01000000, index 2 = 03000001 02000001 03000001 02000001.
  - rk_last only at index 10; store_valid=1 afterwards.
- Same key, dec=1: rk_valid=0 for T+1..T+10, first key at T+11 with index 10.
  - Indices 10..0 match the forward run; index 1 = 01000000 x4; rk_last at index 0.
- Forward run with rk_ready toggled 1,0,0,1: rk_data/rk_index held during stalls, no skipped or duplicated indices, identical key sequence.
- After a completed load, replay with dec=1: first key next cycle, index 10 equals the earlier value.
  - key_load+replay same cycle: load wins, store_valid drops to 0.
- abort at index 4 of a dec=0 load: IDLE next cycle, rk_valid=0, store_valid=0, replay request ignored. rst_n low mid-FILL: outputs zero immediately.
